volatility_sched: RTL
=====================

// Module: volatility_sched
// PURPOSE
//  Front-end scheduler for the per-stock volatility buffer datapath.
//  Round-robin arbitrates NUM_FEEDS best-bid/ask requesters, issuing at most one update per cycle.
//  Owns each stock's circular write pointer and fill count, and generates the flat buffer write address.
//  Sequences a per-stock clear by scrubbing that stock's window with zero-valued writes.
//  Sits between the market-data feed handlers and the volatility datapath; the datapath has no backpressure.
// PARAMETERS
//  DATA_WIDTH   32  price width (best ask / best bid)
//  BUFFER_SIZE  20  window depth per stock (>=2)
//  NUM_STOCKS   4   number of tracked stocks
//  NUM_FEEDS    2   number of arbitrated requesters (>=1)
// PORTS
//  i_clk              in   1                          clock
//  i_reset_n          in   1                          synchronous, active-low reset
//  i_feed_valid       in   NUM_FEEDS                  per-feed update request
//  i_feed_stock_id    in   NUM_FEEDS*SW               packed stock ids; SW=$clog2(NUM_STOCKS)
//  i_feed_ask         in   NUM_FEEDS*DATA_WIDTH       packed best ask
//  i_feed_bid         in   NUM_FEEDS*DATA_WIDTH       packed best bid
//  o_feed_ready       out  NUM_FEEDS                  grant, one-hot or zero
//  i_clear_valid      in   1                          clear-stock request
//  i_clear_stock_id   in   SW                         stock to clear
//  o_clear_ready      out  1                          clear accepted this cycle
//  o_vol_valid        out  1                          update strobe to datapath
//  o_vol_write_address out AW                         AW=$clog2(NUM_STOCKS*BUFFER_SIZE)
//  o_vol_stock_id     out  SW                         stock for this update
//  o_vol_best_ask     out  DATA_WIDTH                 ask forwarded (0 during scrub)
//  o_vol_best_bid     out  DATA_WIDTH                 bid forwarded (0 during scrub)
//  o_warm             out  NUM_STOCKS                 stock window full, volatility meaningful
//  o_busy             out  1                          scrub in progress
// BEHAVIOUR
//  - Reset: all outputs 0; every pointer/count 0; round-robin priority to feed 0; FSM = RUN.
//  - FSM states:
//    - RUN: arbitrate feeds.
//    - SCRUB: issue BUFFER_SIZE zero writes for scrub_id; when the last write issues, go to RUN.
//  - Handshake: transfer on valid&ready. o_feed_ready is combinational from FSM state, i_feed_valid and
//    priority. A requester holds valid and payload stable until ready.
//  - Arbitration: in RUN, grant the first valid feed at or after the priority pointer. On a grant,
//    priority becomes granted index+1 (mod NUM_FEEDS). No valid feeds: no grant, pointer unchanged.
//  - Clear: o_clear_ready = i_clear_valid && state==RUN. Clear beats feeds in the same cycle (no feed
//    grant). Enter SCRUB with scrub_id latched and the walk starting at ptr[scrub_id].
//  - Issue latency: 1 cycle. Outputs are registered; o_vol_* is valid the cycle after the grant or scrub step.
//  - Address: o_vol_write_address = stock_id*BUFFER_SIZE + ptr[stock_id].
//  - Pointer wrap: on issue, ptr advances; ptr==BUFFER_SIZE-1 wraps to 0.
//  - Fill count: cnt[s] saturates at BUFFER_SIZE. o_warm[s] = (cnt[s]==BUFFER_SIZE), registered with the issue.
//  - SCRUB: each cycle emits o_vol_valid=1, ask=bid=0, address walking from ptr[scrub_id] with wrap. This
//    evicts every old sample, so the datapath sums return to 0. After BUFFER_SIZE writes: ptr[scrub_id]=0,
//    cnt[scrub_id]=0, o_warm[scrub_id]=0. o_busy=1 throughout; o_feed_ready=0, o_clear_ready=0.
//  - Clear of a stock with cnt=0 still runs the full scrub (uniform timing).
//  - Reset mid-scrub: abort immediately, return to reset state; the datapath shares the reset.
//  - Out-of-range stock id (>=NUM_STOCKS): the request is granted and dropped, no o_vol_valid.
//  - Arithmetic: ask/bid forwarded unmodified; the mid-price computation stays in the datapath.
// STRUCTURE
//  - vol_pkg: state_t enum {RUN, SCRUB}; localparams AW and SW; function base_addr(stock_id).
//    Shared with the volatility datapath.
//  - Sub-module rr_arbiter #(N): req in, one-hot grant out, advance strobe; reused by other
//    order-book schedulers.
//  - Pointer/count arrays and FSM stay in this module.
// TESTING  (BUFFER_SIZE=4, NUM_STOCKS=4, NUM_FEEDS=2)
//  1. Feed0 sends 5 updates to stock 2 -> addresses 8,9,10,11,8. o_warm[2] rises with the 4th write.
//     Each write lands 1 cycle after ready.
//  2. Both feeds valid for 4 cycles, stocks 0/1 -> grants alternate 0,1,0,1. Addresses 0,4,1,5.
//  3. Stock 1 warm with ptr=2; clear stock 1 -> o_busy for 4 cycles, writes to 6,7,4,5 with ask=bid=0.
//     Then o_warm[1]=0 and the next stock-1 write goes to 4.
//  4. Clear and feed0 valid in the same cycle -> clear accepted, o_feed_ready=0.
//     Feed0 is granted the cycle after scrub ends.
//  5. Reset asserted on the 2nd scrub cycle -> next cycle all outputs 0, o_busy=0, next stock-0 write at address 0.
//  6. Feed with stock_id issue past NUM_STOCKS (NUM_STOCKS=3) -> ready=1, no o_vol_valid, pointers unchanged.

Source files
------------

// File: rtl/vol_pkg.sv
// Shared types and address helpers for the volatility scheduler and datapath.
// Latency: none (types, constants and a pure function only).
// Backpressure: none (no signals).
package vol_pkg;

   // Default build configuration of the volatility datapath
   localparam int VOL_DATA_WIDTH  = 32;
   localparam int VOL_BUFFER_SIZE = 20;
   localparam int VOL_NUM_STOCKS  = 4;
   localparam int VOL_NUM_FEEDS   = 2;

   // Stock-id and flat buffer address widths for the default build
   localparam int SW = (VOL_NUM_STOCKS > 1) ? $clog2(VOL_NUM_STOCKS) : 1;
   localparam int AW = $clog2(VOL_NUM_STOCKS * VOL_BUFFER_SIZE);

   typedef enum logic {
      RUN   = 1'b0,
      SCRUB = 1'b1
   } state_t;

   // First flat buffer address of a stock's window
   function automatic int base_addr(input int stock_id, input int buffer_size);
      return stock_id * buffer_size;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the priority pointer.
// Latency: grant is combinational; the priority pointer updates on the clock after an advance.
// Backpressure: none inside; the caller masks requests and strobes advance when a grant is taken.
module rr_arbiter #(
   parameter int N = 2,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic [N-1:0] i_req,
   input  logic         i_advance,
   output logic [N-1:0] o_grant
);

   logic [PW-1:0] prio;
   logic [PW-1:0] prio_next;
   logic          found;

   // Scan from the priority pointer, wrapping, and pick the first request
   always_comb begin
      o_grant   = '0;
      prio_next = prio;
      found     = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && i_req[(int'(prio) + i) % N]) begin
            o_grant[(int'(prio) + i) % N] = 1'b1;
            prio_next = PW'((int'(prio) + i + 1) % N);
            found     = 1'b1;
         end
      end
   end

   // Move priority just past the granted requester
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         prio <= '0;
      end else if (i_advance) begin
         prio <= prio_next;
      end
   end

endmodule

// File: rtl/volatility_sched.sv
// Volatility front-end: arbitrates feeds, owns per-stock window pointers, scrubs a stock on clear.
// Latency: one cycle from grant or scrub step to o_vol_* strobe.
// Backpressure: datapath never stalls; feeds and clears are held off only by arbitration or an active scrub.
module volatility_sched
   import vol_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int BUFFER_SIZE = 20,
   parameter int NUM_STOCKS  = 4,
   parameter int NUM_FEEDS   = 2,
   localparam int SID_W  = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1,
   localparam int ADDR_W = $clog2(NUM_STOCKS * BUFFER_SIZE)
) (
   input  logic                          i_clk,
   input  logic                          i_reset_n,
   input  logic [NUM_FEEDS-1:0]          i_feed_valid,
   input  logic [NUM_FEEDS*SID_W-1:0]    i_feed_stock_id,
   input  logic [NUM_FEEDS*DATA_WIDTH-1:0] i_feed_ask,
   input  logic [NUM_FEEDS*DATA_WIDTH-1:0] i_feed_bid,
   output logic [NUM_FEEDS-1:0]          o_feed_ready,
   input  logic                          i_clear_valid,
   input  logic [SID_W-1:0]              i_clear_stock_id,
   output logic                          o_clear_ready,
   output logic                          o_vol_valid,
   output logic [ADDR_W-1:0]             o_vol_write_address,
   output logic [SID_W-1:0]              o_vol_stock_id,
   output logic [DATA_WIDTH-1:0]         o_vol_best_ask,
   output logic [DATA_WIDTH-1:0]         o_vol_best_bid,
   output logic [NUM_STOCKS-1:0]         o_warm,
   output logic                          o_busy
);

   localparam int PW = $clog2(BUFFER_SIZE);
   localparam int CW = $clog2(BUFFER_SIZE + 1);

   state_t           state;
   logic [SID_W-1:0] scrub_id;
   logic [CW-1:0]    scrub_left;
   logic [PW-1:0]    ptr [NUM_STOCKS];
   logic [CW-1:0]    cnt [NUM_STOCKS];

   logic                  run;
   logic [NUM_FEEDS-1:0]  arb_req;
   logic [NUM_FEEDS-1:0]  grant;
   logic                  sel_vld;
   logic [SID_W-1:0]      sel_sid;
   logic [DATA_WIDTH-1:0] sel_ask;
   logic [DATA_WIDTH-1:0] sel_bid;
   logic                  sel_in_range;
   logic                  clr_in_range;

   // Window pointer advance with wrap at the end of the window
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (int'(p) == BUFFER_SIZE - 1) ? '0 : p + 1'b1;
   endfunction

   assign run           = (state == RUN);
   // A clear in the same cycle wins over every feed
   assign arb_req       = (run && !i_clear_valid) ? i_feed_valid : '0;
   assign o_feed_ready  = grant;
   assign o_clear_ready = i_clear_valid && run;
   assign o_busy        = (state == SCRUB);
   assign sel_in_range  = (int'(sel_sid) < NUM_STOCKS);
   assign clr_in_range  = (int'(i_clear_stock_id) < NUM_STOCKS);

   rr_arbiter #(.N(NUM_FEEDS)) u_arb (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_req     (arb_req),
      .i_advance (|grant),
      .o_grant   (grant)
   );

   // Steer the granted feed's payload to the issue stage
   always_comb begin
      sel_vld = 1'b0;
      sel_sid = '0;
      sel_ask = '0;
      sel_bid = '0;
      for (int f = 0; f < NUM_FEEDS; f++) begin
         if (grant[f]) begin
            sel_vld = 1'b1;
            sel_sid = i_feed_stock_id[f*SID_W +: SID_W];
            sel_ask = i_feed_ask[f*DATA_WIDTH +: DATA_WIDTH];
            sel_bid = i_feed_bid[f*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // RUN/SCRUB sequencing, per-stock pointer/count upkeep and registered issue
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state               <= RUN;
         scrub_id            <= '0;
         scrub_left          <= '0;
         o_vol_valid         <= 1'b0;
         o_vol_write_address <= '0;
         o_vol_stock_id      <= '0;
         o_vol_best_ask      <= '0;
         o_vol_best_bid      <= '0;
         o_warm              <= '0;
         for (int s = 0; s < NUM_STOCKS; s++) begin
            ptr[s] <= '0;
            cnt[s] <= '0;
         end
      end else begin
         o_vol_valid <= 1'b0;
         case (state)
            RUN: begin
               if (i_clear_valid) begin
                  // A clear naming no real stock is accepted and has nothing to scrub
                  if (clr_in_range) begin
                     state      <= SCRUB;
                     scrub_id   <= i_clear_stock_id;
                     scrub_left <= CW'(BUFFER_SIZE);
                  end
               end else if (sel_vld && sel_in_range) begin
                  o_vol_valid         <= 1'b1;
                  o_vol_write_address <= ADDR_W'(base_addr(int'(sel_sid), BUFFER_SIZE) + int'(ptr[sel_sid]));
                  o_vol_stock_id      <= sel_sid;
                  o_vol_best_ask      <= sel_ask;
                  o_vol_best_bid      <= sel_bid;
                  ptr[sel_sid]        <= ptr_inc(ptr[sel_sid]);
                  if (int'(cnt[sel_sid]) != BUFFER_SIZE) begin
                     cnt[sel_sid] <= cnt[sel_sid] + 1'b1;
                  end
                  o_warm[sel_sid] <= (int'(cnt[sel_sid]) >= BUFFER_SIZE - 1);
               end
            end
            SCRUB: begin
               // Zero write at the current slot evicts the oldest sample
               o_vol_valid         <= 1'b1;
               o_vol_write_address <= ADDR_W'(base_addr(int'(scrub_id), BUFFER_SIZE) + int'(ptr[scrub_id]));
               o_vol_stock_id      <= scrub_id;
               o_vol_best_ask      <= '0;
               o_vol_best_bid      <= '0;
               scrub_left          <= scrub_left - 1'b1;
               if (scrub_left == CW'(1)) begin
                  ptr[scrub_id]    <= '0;
                  cnt[scrub_id]    <= '0;
                  o_warm[scrub_id] <= 1'b0;
                  state            <= RUN;
               end else begin
                  ptr[scrub_id] <= ptr_inc(ptr[scrub_id]);
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule
